load_store_unit: RTL and testbench

Core-side initiator for data memory accesses. Accepts one load or store per handshake from the execute stage, checks alignment, drives a word-wide request/acknowledge bus with byte enables and lane-shifted store data, and returns the load result sign- or zero-extended from the addressed lane. The memory side is the responder. `busy` stalls the pipeline while an access is outstanding.

---
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response and word-bus signals of the load/store unit.
// master: the load/store unit; slave: the execute stage plus memory responder.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] Addr;
  logic [31:0] Write_Data;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        resp_valid;
  logic [31:0] LoadOut;
  logic        misaligned;
  logic        bus_err;
  logic        busy;

  modport master (
    input  req_valid, MemRead, MemWrite, funct3, Addr, Write_Data, bus_ack, bus_rdata,
    output req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
           resp_valid, LoadOut, misaligned, bus_err, busy
  );

  modport slave (
    output req_valid, MemRead, MemWrite, funct3, Addr, Write_Data, bus_ack, bus_rdata,
    input  req_ready, bus_req, bus_we, bus_addr, bus_be, bus_wdata,
           resp_valid, LoadOut, misaligned, bus_err, busy
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time from the execute stage onto a
// word-wide req/ack bus, with alignment checking, lane steering and
// sign/zero extension of load results. Access aborts after TIMEOUT cycles.
module load_store_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.master lsu
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t      state, next_state;
  logic        op_load;
  logic [2:0]  op_f3;
  logic [1:0]  op_lane;
  logic [7:0]  wait_cnt;
  logic        accept, req_fault, timeout_hit;

  // funct3 legality (store wins when both strobes are set) plus natural alignment
  function automatic logic check_fault(input logic st, input logic [2:0] f3,
                                       input logic [1:0] lo);
    logic legal, flt;
    if (st) legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    legal = (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
    case (f3[1:0])
      2'b01:   flt = !legal || lo[0];
      2'b10:   flt = !legal || (lo != 2'b00);
      default: flt = !legal;
    endcase
    return flt;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = 4'b0011 << {lo[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data is replicated so every enabled lane sees the right bytes
  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] d;
    case (sz)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] w);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] r;
    b  = w[{lane, 3'b000} +: 8];
    h  = lane[1] ? w[31:16] : w[15:0];
    sb = b;
    sh = h;
    case (f3)
      3'b000:  r = 32'(sb);
      3'b100:  r = {24'b0, b};
      3'b001:  r = 32'(sh);
      3'b101:  r = {16'b0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign accept      = (state == IDLE) && lsu.req_valid && (lsu.MemRead || lsu.MemWrite);
  assign req_fault   = check_fault(lsu.MemWrite, lsu.funct3, lsu.Addr[1:0]);
  assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

  assign lsu.req_ready  = (state == IDLE);
  assign lsu.busy       = (state != IDLE);
  assign lsu.bus_req    = (state == ACCESS);
  assign lsu.resp_valid = (state == RESP);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; ack takes priority over a timeout on the same edge
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = req_fault ? RESP : ACCESS;
      ACCESS:  if (lsu.bus_ack || timeout_hit) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch, bus drive registers, wait counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_load        <= 1'b0;
      op_f3          <= 3'b0;
      op_lane        <= 2'b0;
      wait_cnt       <= 8'd0;
      lsu.bus_we     <= 1'b0;
      lsu.bus_addr   <= 32'b0;
      lsu.bus_be     <= 4'b0;
      lsu.bus_wdata  <= 32'b0;
      lsu.LoadOut    <= 32'b0;
      lsu.misaligned <= 1'b0;
      lsu.bus_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_load  <= !lsu.MemWrite;
            op_f3    <= lsu.funct3;
            op_lane  <= lsu.Addr[1:0];
            wait_cnt <= 8'd0;
            if (req_fault) begin
              lsu.misaligned <= 1'b1;
            end else begin
              lsu.bus_we    <= lsu.MemWrite;
              lsu.bus_addr  <= {lsu.Addr[31:2], 2'b00};
              lsu.bus_be    <= lane_be(lsu.funct3[1:0], lsu.Addr[1:0]);
              lsu.bus_wdata <= lane_wdata(lsu.funct3[1:0], lsu.Write_Data);
            end
          end
        end
        ACCESS: begin
          if (lsu.bus_ack || timeout_hit) begin
            lsu.bus_we    <= 1'b0;
            lsu.bus_addr  <= 32'b0;
            lsu.bus_be    <= 4'b0;
            lsu.bus_wdata <= 32'b0;
            if (lsu.bus_ack) begin
              if (op_load) lsu.LoadOut <= load_extend(op_f3, op_lane, lsu.bus_rdata);
            end else begin
              lsu.bus_err <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          lsu.LoadOut    <= 32'b0;
          lsu.misaligned <= 1'b0;
          lsu.bus_err    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-lane reference model.
module tb_load_store_unit;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  logic [31:0] last_load, last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;

  load_store_unit_if lsu();

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .lsu (lsu)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: width in bytes from funct3, lanes computed arithmetically
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output bit flt, output logic [3:0] be,
                                output logic [31:0] wdat, output logic [31:0] ld);
    bit legal;
    int w, off;
    logic [31:0] mask;
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    w     = 1 << f3[1:0];
    off   = int'(a[1:0]);
    flt   = !legal || ((off % w) != 0);
    be    = 4'(((1 << w) - 1) << off);
    for (int i = 0; i < 4; i++) wdat[8*i +: 8] = wd[8*(i % w) +: 8];
    mask = (w >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * w)) - 32'd1);
    ld   = (rd >> (8 * off)) & mask;
    if (!f3[2] && w < 4 && ld[8*w-1]) ld = ld | ~mask;
  endfunction

  // delay: cycle of bus_req on which ack is given (1 = first); 0 = never
  task automatic run_access(input bit st, input bit rd_en, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int delay);
    bit flt, exp_err;
    logic [3:0]  be;
    logic [31:0] wdat, ld;
    int cnt, exp_cnt;
    model(st, f3, a, wd, rd, flt, be, wdat, ld);
    check("ready_before", 32'(lsu.req_ready), 32'd1);
    lsu.req_valid  = 1'b1;
    lsu.MemWrite   = st;
    lsu.MemRead    = rd_en;
    lsu.funct3     = f3;
    lsu.Addr       = a;
    lsu.Write_Data = wd;
    @(negedge clk);
    lsu.req_valid  = 1'b0;
    lsu.Addr       = $urandom;
    lsu.Write_Data = $urandom;
    lsu.funct3     = 3'($urandom);
    if (flt) begin
      check("flt_resp", 32'(lsu.resp_valid), 32'd1);
      check("flt_mis", 32'(lsu.misaligned), 32'd1);
      check("flt_err", 32'(lsu.bus_err), 32'd0);
      check("flt_breq", 32'(lsu.bus_req), 32'd0);
      check("flt_load", lsu.LoadOut, 32'd0);
      last_load = lsu.LoadOut;
    end else begin
      exp_err = (delay == 0) || (delay > TO);
      exp_cnt = exp_err ? TO : delay;
      cnt = 0;
      while (lsu.bus_req === 1'b1 && cnt < TO + 10) begin
        cnt++;
        if (cnt == 1) begin
          check("bus_addr", lsu.bus_addr, {a[31:2], 2'b00});
          check("bus_be", 32'(lsu.bus_be), 32'(be));
          check("bus_we", 32'(lsu.bus_we), 32'(st));
          if (st) check("bus_wdata", lsu.bus_wdata, wdat);
          last_addr  = lsu.bus_addr;
          last_be    = lsu.bus_be;
          last_we    = lsu.bus_we;
          last_wdata = lsu.bus_wdata;
        end
        if (cnt == delay) begin
          lsu.bus_ack   = 1'b1;
          lsu.bus_rdata = rd;
        end
        @(negedge clk);
        lsu.bus_ack   = 1'b0;
        lsu.bus_rdata = $urandom;
      end
      check("req_cycles", 32'(cnt), 32'(exp_cnt));
      check("resp_valid", 32'(lsu.resp_valid), 32'd1);
      check("bus_err", 32'(lsu.bus_err), 32'(exp_err));
      check("misaligned", 32'(lsu.misaligned), 32'd0);
      check("load_out", lsu.LoadOut, (st || exp_err) ? 32'd0 : ld);
      last_load = lsu.LoadOut;
      if (exp_err) lsu.bus_ack = 1'b1;
    end
    @(negedge clk);
    lsu.bus_ack = 1'b0;
    check("resp_one_cycle", 32'(lsu.resp_valid), 32'd0);
    check("ready_after", 32'(lsu.req_ready), 32'd1);
    check("breq_after", 32'(lsu.bus_req), 32'd0);
    check("flags_clear", 32'({lsu.misaligned, lsu.bus_err}), 32'd0);
  endtask

  initial begin
    bit st, rdn;
    logic [2:0] f3;
    int r, dly, bad;
    logic [2:0] ld_codes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst = 1'b1;
    lsu.req_valid = 1'b0; lsu.MemRead = 1'b0; lsu.MemWrite = 1'b0;
    lsu.funct3 = 3'd0; lsu.Addr = 32'd0; lsu.Write_Data = 32'd0;
    lsu.bus_ack = 1'b0; lsu.bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_breq", 32'(lsu.bus_req), 32'd0);
    check("rst_we", 32'(lsu.bus_we), 32'd0);
    check("rst_resp", 32'(lsu.resp_valid), 32'd0);
    check("rst_flags", 32'({lsu.misaligned, lsu.bus_err}), 32'd0);
    check("rst_busy", 32'(lsu.busy), 32'd0);
    check("rst_ready", 32'(lsu.req_ready), 32'd1);
    check("rst_addr", lsu.bus_addr, 32'd0);
    check("rst_be", 32'(lsu.bus_be), 32'd0);
    check("rst_wdata", lsu.bus_wdata, 32'd0);
    check("rst_load", lsu.LoadOut, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_access(1'b0, 1'b1, 3'b000, 32'h13, 32'h0, 32'h80FF7F00, 1);
    check("lb_load", last_load, 32'hFFFFFF80);
    check("lb_be", 32'(last_be), 32'h8);
    check("lb_addr", last_addr, 32'h10);

    run_access(1'b1, 1'b0, 3'b001, 32'h22, 32'h1234ABCD, 32'h0, 2);
    check("sh_be", 32'(last_be), 32'hC);
    check("sh_wdata", last_wdata, 32'hABCDABCD);
    check("sh_we", 32'(last_we), 32'd1);
    check("sh_load", last_load, 32'd0);

    run_access(1'b0, 1'b1, 3'b010, 32'h05, 32'h0, 32'h0, 1);
    run_access(1'b1, 1'b0, 3'b100, 32'h08, 32'h55, 32'h0, 1);
    run_access(1'b1, 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1);
    check("both_we", 32'(last_we), 32'd1);
    check("both_be", 32'(last_be), 32'h2);
    run_access(1'b0, 1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 0);
    run_access(1'b0, 1'b1, 3'b010, 32'h44, 32'h0, 32'hCAFEF00D, TO);

    // Strobe-less request and stray ack are both ignored
    lsu.req_valid = 1'b1; lsu.MemRead = 1'b0; lsu.MemWrite = 1'b0;
    @(negedge clk);
    lsu.req_valid = 1'b0;
    check("noop_ready", 32'(lsu.req_ready), 32'd1);
    check("noop_breq", 32'(lsu.bus_req), 32'd0);
    lsu.bus_ack = 1'b1;
    @(negedge clk);
    lsu.bus_ack = 1'b0;
    check("stray_ack", 32'(lsu.resp_valid), 32'd0);

    // Reset while waiting for ack
    lsu.req_valid = 1'b1; lsu.MemRead = 1'b1; lsu.MemWrite = 1'b0;
    lsu.funct3 = 3'b010; lsu.Addr = 32'h80;
    @(negedge clk);
    lsu.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_breq", 32'(lsu.bus_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_breq", 32'(lsu.bus_req), 32'd0);
    check("mid_rst_ready", 32'(lsu.req_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) lsu.bus_ack = 1'b1;
      if (lsu.resp_valid !== 1'b0) bad++;
      @(negedge clk);
      lsu.bus_ack = 1'b0;
    end
    check("mid_rst_noresp", 32'(bad), 32'd0);
    run_access(1'b0, 1'b1, 3'b101, 32'h02, 32'h0, 32'hFFEE0000, 3);
    check("lhu_load", last_load, 32'h0000FFEE);

    for (int n = 0; n < 200; n++) begin
      st  = 1'($urandom_range(0, 1));
      rdn = st ? 1'($urandom_range(0, 1)) : 1'b1;
      if ($urandom_range(0, 3) != 0)
        f3 = st ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
      else
        f3 = 3'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      dly = 0;
      else if (r == 9) dly = TO;
      else             dly = $urandom_range(1, 4);
      run_access(st, rdn, f3, $urandom, $urandom, $urandom, dly);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
